// File: rtl/halver_unpipe.sv
// rtl/halver_unpipe.sv - decodes the doubled/saturated stream into samples behind a 2-entry output buffer (optional counters: HALVER_STATS_EN)
module halver_unpipe #(
   parameter int DATA_W   = 8,
   parameter int SAT_CODE = 255,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready_out,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic              sat_out,
   output logic              err_out,
   input  logic              ready_in,
   output logic [CNT_W-1:0]  sat_count,
   output logic [CNT_W-1:0]  err_count
);

   // Saturation marker and the sample it stands for (first value that overflowed when doubled).
   localparam logic [DATA_W-1:0] SAT_WORD = DATA_W'(SAT_CODE);
   localparam logic [DATA_W-1:0] SAT_DATA = DATA_W'(1) << (DATA_W - 1);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t state;

   // Second buffer entry; the head entry is the output registers themselves.
   logic [DATA_W-1:0] spare_data;
   logic              spare_sat;
   logic              spare_err;

   // Decoded view of the incoming word.
   logic [DATA_W-1:0] dec_data;
   logic              dec_sat;
   logic              dec_err;

   logic push;
   logic pop;

   assign push = valid_in && ready_out;
   assign pop  = valid_out && ready_in;

   // Decode: halve even codes, map the marker to the saturated sample, flag odd codes.
   always_comb begin
      dec_data = data_in >> 1;
      dec_sat  = 1'b0;
      dec_err  = 1'b0;
      if (data_in == SAT_WORD) begin
         dec_data = SAT_DATA;
         dec_sat  = 1'b1;
      end else if (data_in[0]) begin
         dec_err = 1'b1;
      end
   end

   // Buffer FSM: the head drives the outputs, ready_out tracks free space one edge ahead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         ready_out  <= 1'b1;
         valid_out  <= 1'b0;
         data_out   <= '0;
         sat_out    <= 1'b0;
         err_out    <= 1'b0;
         spare_data <= '0;
         spare_sat  <= 1'b0;
         spare_err  <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  data_out  <= dec_data;
                  sat_out   <= dec_sat;
                  err_out   <= dec_err;
                  valid_out <= 1'b1;
                  state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && !pop) begin
                  spare_data <= dec_data;
                  spare_sat  <= dec_sat;
                  spare_err  <= dec_err;
                  ready_out  <= 1'b0;
                  state      <= ST_TWO;
               end else if (pop && !push) begin
                  valid_out <= 1'b0;
                  state     <= ST_EMPTY;
               end else if (push && pop) begin
                  // Head leaves and the new word replaces it directly.
                  data_out <= dec_data;
                  sat_out  <= dec_sat;
                  err_out  <= dec_err;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  data_out  <= spare_data;
                  sat_out   <= spare_sat;
                  err_out   <= spare_err;
                  ready_out <= 1'b1;
                  state     <= ST_ONE;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               ready_out <= 1'b1;
               valid_out <= 1'b0;
            end
         endcase
      end
   end

`ifdef HALVER_STATS_EN
   // Saturating push-time counters of saturated and illegal words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
         err_count <= '0;
      end else if (push) begin
         if (dec_sat && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + CNT_W'(1);
         end
         if (dec_err && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end
`else
   assign sat_count = '0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_halver_unpipe.sv
// tb/tb_halver_unpipe.sv - directed self-checking bench for halver_unpipe
module tb_halver_unpipe;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             valid_in;
   logic [7:0]       data_in;
   logic             ready_out;
   logic             valid_out;
   logic [7:0]       data_out;
   logic             sat_out;
   logic             err_out;
   logic             ready_in;
   logic [CNT_W-1:0] sat_count;
   logic [CNT_W-1:0] err_count;

   int checks;
   int errors;

   halver_unpipe #(.DATA_W(8), .SAT_CODE(255), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_out (ready_out),
      .valid_out (valid_out),
      .data_out  (data_out),
      .sat_out   (sat_out),
      .err_out   (err_out),
      .ready_in  (ready_in),
      .sat_count (sat_count),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic do_reset();
      rst_n    = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'd0;
      ready_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'd0;
      ready_in = 1'b1;
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_out); end
      checks++; if ({data_out, sat_out, err_out} !== 10'd0) begin errors++; $display("FAIL reset_outputs: got %h/%b/%b want 00/0/0", data_out, sat_out, err_out); end
      checks++; if ({sat_count, err_count} !== '0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", sat_count, err_count); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_decode();
      logic [7:0] ins [5];
      logic [7:0] exp [5];
      ins = '{8'd0, 8'd2, 8'd100, 8'd254, 8'd255};
      exp = '{8'd0, 8'd1, 8'd50, 8'd127, 8'd128};
      do_reset();
      ready_in = 1'b1;
      valid_in = 1'b1;
      data_in  = ins[0];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (valid_out !== 1'b1 || data_out !== exp[i]) begin errors++; $display("FAIL decode_data[%0d]: got v=%b d=%0d want v=1 d=%0d", i, valid_out, data_out, exp[i]); end
         checks++; if (sat_out !== (i == 4) || err_out !== 1'b0) begin errors++; $display("FAIL decode_flags[%0d]: got sat=%b err=%b want sat=%b err=0", i, sat_out, err_out, (i == 4)); end
         if (i < 4) data_in = ins[i+1];
         else valid_in = 1'b0;
      end
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL decode_drain: got valid=%b want 0", valid_out); end
`ifdef HALVER_STATS_EN
      checks++; if (sat_count !== 4'd1 || err_count !== 4'd0) begin errors++; $display("FAIL decode_counts: got %0d/%0d want 1/0", sat_count, err_count); end
`else
      checks++; if (sat_count !== 4'd0 || err_count !== 4'd0) begin errors++; $display("FAIL decode_counts: got %0d/%0d want 0/0", sat_count, err_count); end
`endif
   endtask

   task automatic test_illegal();
      do_reset();
      ready_in = 1'b0;
      valid_in = 1'b1;
      data_in  = 8'd7;
      @(negedge clk);
      valid_in = 1'b0;
      checks++; if (valid_out !== 1'b1 || data_out !== 8'd3 || err_out !== 1'b1 || sat_out !== 1'b0) begin errors++; $display("FAIL illegal_decode: got v=%b d=%0d err=%b sat=%b want 1/3/1/0", valid_out, data_out, err_out, sat_out); end
`ifdef HALVER_STATS_EN
      checks++; if (err_count !== 4'd1) begin errors++; $display("FAIL illegal_count: got %0d want 1", err_count); end
`else
      checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL illegal_count: got %0d want 0", err_count); end
`endif
      ready_in = 1'b1;
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL illegal_pop: got valid=%b want 0", valid_out); end
   endtask

   task automatic test_backpressure();
      do_reset();
      ready_in = 1'b0;
      valid_in = 1'b1;
      data_in  = 8'd10;
      @(negedge clk);
      checks++; if (ready_out !== 1'b1 || data_out !== 8'd5) begin errors++; $display("FAIL bp_one: got rdy=%b d=%0d want 1/5", ready_out, data_out); end
      data_in = 8'd20;
      @(negedge clk);
      checks++; if (ready_out !== 1'b0 || valid_out !== 1'b1 || data_out !== 8'd5) begin errors++; $display("FAIL bp_two: got rdy=%b v=%b d=%0d want 0/1/5", ready_out, valid_out, data_out); end
      data_in = 8'd30;
      @(negedge clk);
      checks++; if (ready_out !== 1'b0 || data_out !== 8'd5) begin errors++; $display("FAIL bp_hold: got rdy=%b d=%0d want 0/5", ready_out, data_out); end
      ready_in = 1'b1;
      @(negedge clk);
      checks++; if (ready_out !== 1'b1 || data_out !== 8'd10) begin errors++; $display("FAIL bp_release: got rdy=%b d=%0d want 1/10", ready_out, data_out); end
      @(negedge clk);
      valid_in = 1'b0;
      checks++; if (valid_out !== 1'b1 || data_out !== 8'd15) begin errors++; $display("FAIL bp_third: got v=%b d=%0d want 1/15", valid_out, data_out); end
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got valid=%b want 0", valid_out); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ins [3];
      ins = '{8'd4, 8'd6, 8'd8};
      do_reset();
      ready_in = 1'b1;
      valid_in = 1'b1;
      data_in  = ins[0];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (valid_out !== 1'b1 || ready_out !== 1'b1 || data_out !== 8'(i + 2)) begin errors++; $display("FAIL b2b[%0d]: got v=%b rdy=%b d=%0d want 1/1/%0d", i, valid_out, ready_out, data_out, i + 2); end
         if (i < 2) data_in = ins[i+1];
         else valid_in = 1'b0;
      end
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%b want 0", valid_out); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ready_in = 1'b0;
      valid_in = 1'b1;
      data_in  = 8'd255;
      @(negedge clk);
      data_in = 8'd42;
      @(negedge clk);
      valid_in = 1'b0;
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL mid_full: got rdy=%b want 0", ready_out); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin errors++; $display("FAIL mid_async: got v=%b rdy=%b want 0/1", valid_out, ready_out); end
      checks++; if (sat_count !== 4'd0 || err_count !== 4'd0) begin errors++; $display("FAIL mid_counts: got %0d/%0d want 0/0", sat_count, err_count); end
      @(negedge clk);
      rst_n    = 1'b1;
      ready_in = 1'b1;
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_no_replay: got valid=%b want 0", valid_out); end
      valid_in = 1'b1;
      data_in  = 8'd60;
      @(negedge clk);
      valid_in = 1'b0;
      checks++; if (valid_out !== 1'b1 || data_out !== 8'd30) begin errors++; $display("FAIL mid_first: got v=%b d=%0d want 1/30", valid_out, data_out); end
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_drain: got valid=%b want 0", valid_out); end
   endtask

   task automatic test_saturation();
      do_reset();
      ready_in = 1'b1;
      valid_in = 1'b1;
      data_in  = 8'd255;
      repeat (20) @(negedge clk);
      valid_in = 1'b0;
      checks++; if (data_out !== 8'd128 || sat_out !== 1'b1) begin errors++; $display("FAIL sat_decode: got d=%0d sat=%b want 128/1", data_out, sat_out); end
`ifdef HALVER_STATS_EN
      checks++; if (sat_count !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d want 15", sat_count); end
`else
      checks++; if (sat_count !== 4'd0) begin errors++; $display("FAIL sat_count: got %0d want 0", sat_count); end
`endif
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'd0;
      ready_in = 1'b0;
      test_reset();
      test_decode();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
